pwm_power_test_seq: RTL and testbench

PWM_POWER_TEST_SEQ -- requirements
Module: pwm_power_test_seq

---
 rtl/pwm_power_test_seq.sv | 176 +++++++++++++++++
 tb/tb_pwm_power_test_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_power_test_seq.sv
// ESC/servo power-test sequencer: debounced start, arm at minimum duty, ramp to
// maximum, hold, ramp back down. Duty updates only land on PWM frame boundaries.
module pwm_power_test_seq #(
   parameter int DEBOUNCE_CYCLES = 3000000,
   parameter int DUTY_MIN        = 12000,
   parameter int DUTY_MAX        = 24000,
   parameter int STEP            = 600,
   parameter int ARM_FRAMES      = 100,
   parameter int HOLD_FRAMES     = 150
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic        i_frame_tick,
   output logic [17:0] o_duty_esc,
   output logic [17:0] o_duty_servo1,
   output logic [17:0] o_duty_servo2,
   output logic        o_busy,
   output logic        o_done,
   output logic [2:0]  o_state
);

   localparam int              DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [17:0]     D_MIN      = 18'(DUTY_MIN);
   localparam logic [17:0]     D_MAX      = 18'(DUTY_MAX);
   localparam logic [17:0]     MIRROR_SUM = 18'(DUTY_MIN + DUTY_MAX);
   localparam logic [18:0]     STEP_W     = 19'(STEP);
   localparam logic [15:0]     ARM_LAST   = 16'(ARM_FRAMES - 1);
   localparam logic [15:0]     HOLD_LAST  = 16'(HOLD_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ARM       = 3'd1,
      S_RAMP_UP   = 3'd2,
      S_HOLD      = 3'd3,
      S_RAMP_DOWN = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [DB_W-1:0]    db_cnt_r;
   logic               stage1_r;
   logic               stage2_r;
   logic               sample_en_s;
   logic               start_pulse_s;
   logic [15:0]        frame_cnt_r;
   logic [17:0]        esc_r;
   logic [17:0]        esc_nxt_s;
   logic [17:0]        servo1_r;
   logic [17:0]        servo2_r;
   logic               busy_r;
   logic               done_r;
   logic [18:0]        sum_s;
   logic signed [18:0] diff_s;
   logic [17:0]        mirror_s;

   // One extra bit on sum/difference keeps saturation free of wrap-around.
   assign sample_en_s   = (db_cnt_r == DB_LAST);
   assign start_pulse_s = sample_en_s & stage1_r & ~stage2_r;
   assign sum_s         = {1'b0, esc_r} + STEP_W;
   assign diff_s        = signed'({1'b0, esc_r}) - signed'(STEP_W);
   assign mirror_s      = MIRROR_SUM - esc_nxt_s;

   // Slow sampling of the raw start button and its rising-edge history.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         db_cnt_r <= '0;
         stage1_r <= 1'b0;
         stage2_r <= 1'b0;
      end else if (sample_en_s) begin
         db_cnt_r <= '0;
         stage1_r <= i_start;
         stage2_r <= stage1_r;
      end else begin
         db_cnt_r <= db_cnt_r + 1'b1;
      end
   end

   // Next state and next ESC duty; abort overrides every other event.
   always_comb begin
      state_nxt_s = state_r;
      esc_nxt_s   = esc_r;
      if (i_abort) begin
         state_nxt_s = S_IDLE;
         esc_nxt_s   = D_MIN;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start_pulse_s) begin
                  state_nxt_s = S_ARM;
                  esc_nxt_s   = D_MIN;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            S_ARM: begin
               if (i_frame_tick && (frame_cnt_r == ARM_LAST)) begin
                  state_nxt_s = S_RAMP_UP;
               end else begin
                  state_nxt_s = S_ARM;
               end
            end
            S_RAMP_UP: begin
               if (i_frame_tick && (sum_s >= {1'b0, D_MAX})) begin
                  esc_nxt_s   = D_MAX;
                  state_nxt_s = S_HOLD;
               end else if (i_frame_tick) begin
                  esc_nxt_s   = sum_s[17:0];
               end else begin
                  esc_nxt_s   = esc_r;
               end
            end
            S_HOLD: begin
               if (i_frame_tick && (frame_cnt_r == HOLD_LAST)) begin
                  state_nxt_s = S_RAMP_DOWN;
               end else begin
                  state_nxt_s = S_HOLD;
               end
            end
            S_RAMP_DOWN: begin
               if (i_frame_tick && (diff_s <= signed'({1'b0, D_MIN}))) begin
                  esc_nxt_s   = D_MIN;
                  state_nxt_s = S_DONE;
               end else if (i_frame_tick) begin
                  esc_nxt_s   = diff_s[17:0];
               end else begin
                  esc_nxt_s   = esc_r;
               end
            end
            default: begin
               state_nxt_s = S_IDLE;
               esc_nxt_s   = D_MIN;
            end
         endcase
      end
   end

   // State, frame counter and all outputs are registered together.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r     <= S_IDLE;
         frame_cnt_r <= 16'd0;
         esc_r       <= D_MIN;
         servo1_r    <= D_MIN;
         servo2_r    <= D_MAX;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         esc_r    <= esc_nxt_s;
         servo1_r <= esc_nxt_s;
         servo2_r <= mirror_s;
         busy_r   <= (state_nxt_s == S_ARM) || (state_nxt_s == S_RAMP_UP) ||
                     (state_nxt_s == S_HOLD) || (state_nxt_s == S_RAMP_DOWN);
         done_r   <= (state_nxt_s == S_DONE);
         if (state_nxt_s != state_r) begin
            frame_cnt_r <= 16'd0;
         end else if (i_frame_tick) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   assign o_duty_esc    = esc_r;
   assign o_duty_servo1 = servo1_r;
   assign o_duty_servo2 = servo2_r;
   assign o_busy        = busy_r;
   assign o_done        = done_r;
   assign o_state       = state_r;

endmodule

// File: tb/tb_pwm_power_test_seq.sv
// Bench for pwm_power_test_seq: directed scenarios with literal expectations, then
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_pwm_power_test_seq;

   localparam int DB    = 2;
   localparam int DMIN  = 12000;
   localparam int DMAX  = 24000;
   localparam int STEP  = 5000;
   localparam int ARMF  = 2;
   localparam int HOLDF = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort_in;
   logic        tick;
   logic [17:0] esc;
   logic [17:0] servo1;
   logic [17:0] servo2;
   logic        busy;
   logic        done;
   logic [2:0]  st;

   int checks   = 0;
   int failures = 0;

   pwm_power_test_seq #(
      .DEBOUNCE_CYCLES(DB), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
      .STEP(STEP), .ARM_FRAMES(ARMF), .HOLD_FRAMES(HOLDF)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_in),
      .i_frame_tick(tick), .o_duty_esc(esc), .o_duty_servo1(servo1),
      .o_duty_servo2(servo2), .o_busy(busy), .o_done(done), .o_state(st)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase number (spec encoding), duty, ticks since phase entry.
   int m_state;
   int m_esc;
   int m_frames;
   int m_cyc;
   bit m_s1;
   bit m_s2;

   task automatic model_step();
      bit pulse;
      pulse = 1'b0;
      if (rst) begin
         m_state = 0; m_esc = DMIN; m_frames = 0; m_cyc = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
         if ((m_cyc % DB) == DB - 1) begin
            pulse = m_s1 && !m_s2;
            m_s2  = m_s1;
            m_s1  = start;
         end
         m_cyc++;
         if (abort_in) begin
            m_state = 0; m_esc = DMIN; m_frames = 0;
         end else if ((m_state == 0 || m_state == 5) && pulse) begin
            m_state = 1; m_esc = DMIN; m_frames = 0;
         end else if (tick) begin
            m_frames++;
            case (m_state)
               1: if (m_frames == ARMF) begin m_state = 2; m_frames = 0; end
               2: begin
                  m_esc = (m_esc + STEP > DMAX) ? DMAX : m_esc + STEP;
                  if (m_esc == DMAX) begin m_state = 3; m_frames = 0; end
               end
               3: if (m_frames == HOLDF) begin m_state = 4; m_frames = 0; end
               4: begin
                  m_esc = (m_esc - STEP < DMIN) ? DMIN : m_esc - STEP;
                  if (m_esc == DMIN) begin m_state = 5; m_frames = 0; end
               end
               default: ;
            endcase
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         model_step();
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("model_state", int'(st), m_state);
         chk("model_esc", int'(esc), m_esc);
         chk("model_servo1", int'(servo1), m_esc);
         chk("model_servo2", int'(servo2), DMIN + DMAX - m_esc);
         chk("model_busy", int'(busy), (m_state >= 1 && m_state <= 4) ? 1 : 0);
         chk("model_done", int'(done), (m_state == 5) ? 1 : 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
   endtask

   task automatic press();
      start = 1'b1; cyc(3 * DB);
      start = 1'b0; cyc(3 * DB);
   endtask

   task automatic wait_state(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (int'(st) != target && n < budget) begin
         cyc(1);
         n++;
      end
      chk(name, int'(st), target);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort_in = 1'b0; tick = 1'b0;
      cyc(3);
      chk("rst_state", int'(st), 0);
      chk("rst_esc", int'(esc), 12000);
      chk("rst_servo1", int'(servo1), 12000);
      chk("rst_servo2", int'(servo2), 24000);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b0;
      cyc(2);

      // One-cycle glitch placed on an edge that is not a sample enable.
      while ((m_cyc % DB) == DB - 1) cyc(1);
      start = 1'b1; cyc(1); start = 1'b0; cyc(6);
      chk("bounce_state", int'(st), 0);
      chk("idle_servo1", int'(servo1), 12000);
      chk("idle_servo2", int'(servo2), 24000);

      // Nominal sequence.
      press();
      wait_state(1, 20, "arm_entry");
      chk("arm_busy", int'(busy), 1);
      do_tick(); chk("arm_tick1", int'(st), 1);
      do_tick(); chk("arm_tick2_state", int'(st), 2);
      chk("arm_tick2_esc", int'(esc), 12000);
      do_tick(); chk("up1_esc", int'(esc), 17000);
      chk("up1_servo1", int'(servo1), 17000);
      chk("up1_servo2", int'(servo2), 19000);
      chk("up1_model_esc", m_esc, 17000);
      do_tick(); chk("up2_esc", int'(esc), 22000);
      do_tick(); chk("up3_esc", int'(esc), 24000);
      chk("up3_state", int'(st), 3);
      chk("up3_model_state", m_state, 3);
      do_tick(); do_tick(); chk("hold2_state", int'(st), 3);
      do_tick(); chk("hold3_state", int'(st), 4);
      chk("hold3_esc", int'(esc), 24000);
      do_tick(); chk("dn1_esc", int'(esc), 19000);
      do_tick(); chk("dn2_esc", int'(esc), 14000);
      chk("dn2_model_esc", m_esc, 14000);
      do_tick(); chk("dn3_esc", int'(esc), 12000);
      chk("done_state", int'(st), 5);
      chk("done_flag", int'(done), 1);
      chk("done_busy", int'(busy), 0);

      // Restart from DONE, ignored press while busy, then reset mid-ramp.
      press();
      chk("restart_state", int'(st), 1);
      do_tick(); do_tick();
      chk("restart_up", int'(st), 2);
      press();
      chk("busy_press_ignored", int'(st), 2);
      do_tick(); do_tick();
      chk("pre_rst_esc", int'(esc), 22000);
      #2; rst = 1'b1; #1;
      chk("async_rst_state", int'(st), 0);
      chk("async_rst_esc", int'(esc), 12000);
      chk("async_rst_servo1", int'(servo1), 12000);
      chk("async_rst_servo2", int'(servo2), 24000);
      chk("async_rst_busy", int'(busy), 0);
      cyc(2);
      rst = 1'b0;
      cyc(6);
      chk("post_rst_idle", int'(st), 0);

      // Abort in HOLD together with a frame tick.
      press();
      wait_state(1, 20, "abort_arm_entry");
      repeat (5) do_tick();
      do_tick();
      chk("pre_abort_state", int'(st), 3);
      abort_in = 1'b1; tick = 1'b1; cyc(1);
      abort_in = 1'b0; tick = 1'b0;
      chk("abort_state", int'(st), 0);
      chk("abort_esc", int'(esc), 12000);
      chk("abort_busy", int'(busy), 0);
      chk("abort_servo2", int'(servo2), 24000);
      cyc(2);

      // Randomized stimulus; the compare process does the checking.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(11, 0) == 0) start = ~start;
         tick     = ($urandom_range(2, 0) == 0);
         abort_in = ($urandom_range(149, 0) == 0);
         rst      = ($urandom_range(599, 0) == 0);
         cyc(1);
      end
      rst = 1'b0; abort_in = 1'b0; tick = 1'b0; start = 1'b0;
      cyc(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
